seq_ctrl: RTL
=============

Name: seq_ctrl

Overview:
Multi-cycle instruction sequencer for the RV32I core. It steps the datapath through fetch, decode, execute, memory and writeback using one shared instruction/data memory port with a ready handshake. It consumes the decoder's op_illegal, dmem_read, dmem_write and reg_wen flags. It generates the register-enable strobes (IR, PC, register file) and the memory request signals, counts retired instructions, and traps on illegal opcodes or memory timeout.

Parameters:
WAIT_MAX, 255, last wait cycle on which mem_ready is still accepted; legal range 1..65535; counter width is clog2(WAIT_MAX+1)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous active-high reset
run  input  1  level; 1 = keep issuing instructions
op_illegal  input  1  decoder: current IR is illegal
dmem_read  input  1  decoder: current IR is a load
dmem_write  input  1  decoder: current IR is a store
reg_wen_dec  input  1  decoder: current IR writes rd
mem_ready  input  1  memory completes the request this cycle
mem_req  output  1  memory request active
mem_we  output  1  request is a write
mem_sel_data  output  1  address mux: 0 = PC, 1 = ALU result
ir_wen  output  1  latch instruction register
pc_wen  output  1  commit next PC
rf_wen  output  1  register file write strobe
trap  output  1  sticky trap flag
trap_cause  output  2  0 none, 1 illegal opcode, 2 fetch timeout, 3 data timeout
state  output  3  current state encoding, for debug
retired  output  32  retired-instruction count

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Value 7 is unreachable; if it occurs, go to TRAP with cause 1.
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state=IDLE, wait counter=0, trap=0, trap_cause=0, retired=0.
  - All strobes are 0; mem_req drops in the same cycle rst asserts.
- Output timing: strobes are decoded combinationally from state. ir_wen and pc_wen also depend on mem_ready (Mealy). trap, trap_cause and retired are registered.
- IDLE: all strobes 0. If run=1, next state is FETCH.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_sel_data=0.
  - If mem_ready=1: ir_wen=1 this cycle; next state DECODE.
  - Otherwise the wait counter increments.
- DECODE: one cycle, no strobes.
  - op_illegal=1: TRAP, cause 1.
  - Otherwise: EXEC.
- EXEC: one cycle, no strobes.
  - dmem_read or dmem_write: MEM.
  - Otherwise: WB.
- MEM:
  - Drives mem_req=1, mem_sel_data=1, mem_we=dmem_write.
  - On mem_ready with a load: next state WB.
  - On mem_ready with a store: pc_wen=1 this cycle; the instruction retires; next state FETCH if run=1, else IDLE.
- WB: one cycle.
  - rf_wen=reg_wen_dec, pc_wen=1; the instruction retires.
  - Next state FETCH if run=1, else IDLE.
- Timeout:
  - The wait counter clears whenever FETCH or MEM is entered.
  - In FETCH/MEM, if mem_ready=0 while the counter equals WAIT_MAX: next state TRAP, cause 2 (FETCH) or 3 (MEM).
  - mem_ready=1 on that same cycle wins, so no trap is taken.
  - A request is therefore accepted on any of WAIT_MAX+1 cycles.
- TRAP:
  - All strobes 0; trap=1; trap_cause is held.
  - trap and trap_cause are set on the transition into TRAP.
  - Exit only via rst; run is ignored.
- run=0 mid-instruction: the current instruction completes, then the sequencer parks in IDLE. run is sampled only in IDLE and at retire.
- retired: increments by 1 on each retire (WB, or MEM store completion). Wraps from 0xFFFFFFFF to 0.
- Input sampling: decoder inputs are sampled only in DECODE, EXEC, MEM and WB; the IR is stable there. mem_ready is ignored outside FETCH and MEM.
- Latency with zero wait states:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles (FETCH, DECODE, EXEC, MEM).

Test Plan:
- Reset, then run=1, ALU op (reg_wen_dec=1), mem_ready=1 in FETCH -> states 1,2,3,5,1; ir_wen pulses in FETCH; rf_wen=pc_wen=1 in WB; retired=1.
- Load with mem_ready held low 3 cycles in MEM -> mem_req=1, mem_sel_data=1, mem_we=0 for 4 cycles; then WB with rf_wen=1; total 8 cycles; retired increments once.
- Store, zero wait -> mem_we=1 in MEM; pc_wen=1 on the ready cycle; no WB and rf_wen never 1; next state FETCH.
- WAIT_MAX=4, mem_ready never asserted in FETCH -> 5 cycles with mem_req=1, then state=6, trap=1, trap_cause=2. Repeat with ready on the 5th cycle -> no trap, DECODE entered.
- op_illegal=1 in DECODE -> TRAP with cause 1; stays in TRAP with run=1 for 10 cycles; rst mid-TRAP clears trap, trap_cause and retired to 0, state=0.
- Preset retired to 0xFFFFFFFF via forced stimulus, retire one instruction -> retired=0. Drop run during EXEC -> WB completes, then state=0.

Source files
------------

// File: rtl/seq_ctrl.sv
// Multi-cycle RV32I sequencer: walks fetch/decode/execute/memory/writeback over one
// shared memory port, raises register-enable strobes, counts retirements and traps.
module seq_ctrl #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        op_illegal,
   input  logic        dmem_read,
   input  logic        dmem_write,
   input  logic        reg_wen_dec,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_sel_data,
   output logic        ir_wen,
   output logic        pc_wen,
   output logic        rf_wen,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [2:0]  state,
   output logic [31:0] retired
);

   localparam int CW = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   state_t        state_r;
   state_t        state_next_s;
   logic [CW-1:0] wait_r;
   logic [CW-1:0] wait_next_s;
   logic          trap_r;
   logic [1:0]    trap_cause_r;
   logic [1:0]    cause_next_s;
   logic [31:0]   retired_r;
   logic          retire_s;

   // State, wait counter, sticky trap and retire counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= S_IDLE;
         wait_r       <= '0;
         trap_r       <= 1'b0;
         trap_cause_r <= 2'd0;
         retired_r    <= 32'd0;
      end else begin
         state_r <= state_next_s;
         wait_r  <= wait_next_s;
         // cause_next_s is non-zero only on the transition into TRAP
         if (cause_next_s != 2'd0) begin
            trap_r       <= 1'b1;
            trap_cause_r <= cause_next_s;
         end
         if (retire_s) begin
            retired_r <= retired_r + 32'd1;
         end
      end
   end

   // Next-state decode and strobe generation; the wait counter is zero unless stalling.
   always_comb begin
      state_next_s = state_r;
      wait_next_s  = '0;
      cause_next_s = 2'd0;
      retire_s     = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_sel_data = 1'b0;
      ir_wen       = 1'b0;
      pc_wen       = 1'b0;
      rf_wen       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (run) begin
               state_next_s = S_FETCH;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_wen       = 1'b1;
               state_next_s = S_DECODE;
            end else if (wait_r == WAIT_LAST) begin
               state_next_s = S_TRAP;
               cause_next_s = 2'd2;
            end else begin
               wait_next_s = wait_r + CW'(1);
            end
         end
         S_DECODE: begin
            if (op_illegal) begin
               state_next_s = S_TRAP;
               cause_next_s = 2'd1;
            end else begin
               state_next_s = S_EXEC;
            end
         end
         S_EXEC: begin
            if (dmem_read || dmem_write) begin
               state_next_s = S_MEM;
            end else begin
               state_next_s = S_WB;
            end
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_sel_data = 1'b1;
            mem_we       = dmem_write;
            if (mem_ready) begin
               if (dmem_write) begin
                  pc_wen       = 1'b1;
                  retire_s     = 1'b1;
                  state_next_s = run ? S_FETCH : S_IDLE;
               end else begin
                  state_next_s = S_WB;
               end
            end else if (wait_r == WAIT_LAST) begin
               state_next_s = S_TRAP;
               cause_next_s = 2'd3;
            end else begin
               wait_next_s = wait_r + CW'(1);
            end
         end
         S_WB: begin
            rf_wen       = reg_wen_dec;
            pc_wen       = 1'b1;
            retire_s     = 1'b1;
            state_next_s = run ? S_FETCH : S_IDLE;
         end
         S_TRAP: begin
            state_next_s = S_TRAP;
         end
         default: begin
            // Corrupted encoding: fail safe into TRAP as an illegal condition
            state_next_s = S_TRAP;
            cause_next_s = 2'd1;
         end
      endcase
   end

   assign state      = state_r;
   assign trap       = trap_r;
   assign trap_cause = trap_cause_r;
   assign retired    = retired_r;

endmodule
